// File: rtl/box_scheduler.sv
// box_scheduler: round-robin arbitration of box writes into a shadow bank,
// atomic commit of that bank to the overlay outputs at each frame start,
// aging of unrefreshed boxes, and the frame-aligned white-balance strobe.
module box_scheduler #(
   parameter  int N_BOX          = 4,
   parameter  int N_REQ          = 2,
   parameter  int H_ACT          = 1280,
   parameter  int V_ACT          = 720,
   parameter  int TIMEOUT_FRAMES = 8,
   parameter  int WB_PERIOD      = 30,
   localparam int XW             = $clog2(H_ACT),
   localparam int YW             = $clog2(V_ACT),
   localparam int SW             = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vsync,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*SW-1:0]   req_slot,
   input  logic [N_REQ*XW-1:0]   req_sx,
   input  logic [N_REQ*XW-1:0]   req_ex,
   input  logic [N_REQ*YW-1:0]   req_sy,
   input  logic [N_REQ*YW-1:0]   req_ey,
   input  logic [N_REQ*24-1:0]   req_color,
   output logic [N_BOX*XW-1:0]   start_xs,
   output logic [N_BOX*XW-1:0]   end_xs,
   output logic [N_BOX*YW-1:0]   start_ys,
   output logic [N_BOX*YW-1:0]   end_ys,
   output logic [N_BOX*24-1:0]   colors,
   output logic [N_BOX-1:0]      box_valid,
   output logic                  req_err,
   output logic                  wb_update,
   output logic [15:0]           frame_cnt
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int AW = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
   localparam int WW = $clog2(WB_PERIOD + 1);

   typedef struct packed {
      logic [XW-1:0] sx;
      logic [XW-1:0] ex;
      logic [YW-1:0] sy;
      logic [YW-1:0] ey;
      logic [23:0]   color;
   } box_t;

   // Start above end: the overlay matches no pixel for a cleared slot.
   localparam box_t BOX_CLR = {{XW{1'b1}}, {XW{1'b0}}, {YW{1'b1}}, {YW{1'b0}}, 24'h0};

   // Per-requester views of the flat request buses
   logic [SW-1:0] r_slot [N_REQ];
   box_t          r_box  [N_REQ];

   // Arbitration
   logic [PW-1:0] ptr;
   logic [PW:0]   arb_sum;
   logic [PW-1:0] gnt_idx;
   logic          gnt_any;
   logic          hs;
   logic [SW-1:0] g_slot;
   box_t          g_box;
   logic          g_ok;
   logic          wr_en;

   // Banks and aging
   box_t           sh_box  [N_BOX];
   box_t           act_box [N_BOX];
   logic [N_BOX-1:0] sh_v;
   logic [N_BOX-1:0] act_v;
   logic [N_BOX-1:0] refreshed;
   logic [AW-1:0]  age     [N_BOX];
   logic [AW-1:0]  nxt_age [N_BOX];
   logic [N_BOX-1:0] expire;

   // Frame timing
   logic          vsync_d;
   logic          fe;
   logic [WW-1:0] wb_cnt;

   assign fe = vsync & ~vsync_d;

   // Unpack the flat request buses into per-requester fields
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         r_slot[i]       = req_slot[i*SW +: SW];
         r_box[i].sx     = req_sx[i*XW +: XW];
         r_box[i].ex     = req_ex[i*XW +: XW];
         r_box[i].sy     = req_sy[i*YW +: YW];
         r_box[i].ey     = req_ey[i*YW +: YW];
         r_box[i].color  = req_color[i*24 +: 24];
      end
   end

   // Round-robin search from ptr upward with wrap; at most one grant per cycle
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      arb_sum   = '0;
      req_ready = '0;
      for (int k = 0; k < N_REQ; k++) begin
         arb_sum = {1'b0, ptr} + (PW+1)'(k);
         if (int'(arb_sum) >= N_REQ)
            arb_sum = arb_sum - (PW+1)'(N_REQ);
         if (!gnt_any && req_valid[arb_sum[PW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = arb_sum[PW-1:0];
         end
      end
      if (gnt_any && !rst)
         req_ready[gnt_idx] = 1'b1;
   end

   assign hs     = gnt_any & ~rst;
   assign g_slot = r_slot[gnt_idx];
   assign g_box  = r_box[gnt_idx];
   assign g_ok   = (g_box.sx <= g_box.ex) && (g_box.sy <= g_box.ey) &&
                   (int'(g_box.ex) < H_ACT) && (int'(g_box.ey) < V_ACT) &&
                   (int'(g_slot) < N_BOX);
   assign wr_en  = hs & g_ok;

   // Next age per slot at a frame edge and whether it times out there
   always_comb begin
      for (int s = 0; s < N_BOX; s++) begin
         if (refreshed[s])
            nxt_age[s] = '0;
         else if (age[s] == {AW{1'b1}})
            nxt_age[s] = age[s];
         else
            nxt_age[s] = age[s] + 1'b1;
         expire[s] = (TIMEOUT_FRAMES != 0) && (int'(nxt_age[s]) == TIMEOUT_FRAMES);
      end
   end

   // Shadow writes, frame-edge commit to the active bank, aging and expiry
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the bank is a few flops driving the overlay directly, so it is reset rather than left as uninitialised storage.
         for (int s = 0; s < N_BOX; s++) begin
            sh_box[s]  <= BOX_CLR;
            act_box[s] <= BOX_CLR;
            age[s]     <= '0;
         end
         sh_v      <= '0;
         act_v     <= '0;
         refreshed <= '0;
      end else begin
         if (fe) begin
            for (int s = 0; s < N_BOX; s++) begin
               act_box[s] <= sh_box[s];
               act_v[s]   <= sh_v[s];
               age[s]     <= nxt_age[s];
               if (expire[s]) begin
                  act_box[s] <= BOX_CLR;
                  act_v[s]   <= 1'b0;
                  sh_box[s]  <= BOX_CLR;
                  sh_v[s]    <= 1'b0;
               end
            end
            refreshed <= '0;
         end
         // NOTE: non-blocking assignments read pre-edge values and the last one issued wins, so a write here overrides the frame-edge clear/flag reset above while the commit still sees the old shadow.
         if (wr_en) begin
            sh_box[g_slot]    <= g_box;
            sh_v[g_slot]      <= 1'b1;
            refreshed[g_slot] <= 1'b1;
         end
      end
   end

   // Pointer, error pulse, frame counter and white-balance strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_d   <= 1'b1;
         ptr       <= '0;
         req_err   <= 1'b0;
         frame_cnt <= '0;
         wb_cnt    <= '0;
         wb_update <= 1'b0;
      end else begin
         vsync_d   <= vsync;
         req_err   <= hs & ~g_ok;
         wb_update <= 1'b0;
         if (hs)
            ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
         if (fe) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (int'(wb_cnt) == WB_PERIOD - 1) begin
               wb_cnt    <= '0;
               wb_update <= 1'b1;
            end else begin
               wb_cnt <= wb_cnt + 1'b1;
            end
         end
      end
   end

   // Flatten the active bank onto the overlay configuration ports
   always_comb begin
      for (int s = 0; s < N_BOX; s++) begin
         start_xs[s*XW +: XW] = act_box[s].sx;
         end_xs[s*XW +: XW]   = act_box[s].ex;
         start_ys[s*YW +: YW] = act_box[s].sy;
         end_ys[s*YW +: YW]   = act_box[s].ey;
         colors[s*24 +: 24]   = act_box[s].color;
      end
   end

   assign box_valid = act_v;

endmodule

// File: tb/tb_box_scheduler.sv
// Scoreboard bench for box_scheduler: stimulus pushes expected grants,
// error pulses, committed box banks and wb strobes; a negedge monitor pops
// and compares whenever the DUT presents the corresponding event.
module tb_box_scheduler;

   localparam int N_BOX = 4;
   localparam int N_REQ = 2;
   localparam int XW    = 11;
   localparam int YW    = 10;
   localparam int SW    = 2;
   localparam int SNW   = N_BOX * (1 + 2*XW + 2*YW + 24);

   logic                clk;
   logic                rst;
   logic                vsync;
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ*SW-1:0] req_slot;
   logic [N_REQ*XW-1:0] req_sx, req_ex;
   logic [N_REQ*YW-1:0] req_sy, req_ey;
   logic [N_REQ*24-1:0] req_color;
   logic [N_BOX*XW-1:0] start_xs, end_xs;
   logic [N_BOX*YW-1:0] start_ys, end_ys;
   logic [N_BOX*24-1:0] colors;
   logic [N_BOX-1:0]    box_valid;
   logic                req_err;
   logic                wb_update;
   logic [15:0]         frame_cnt;

   box_scheduler #(
      .N_BOX(N_BOX), .N_REQ(N_REQ), .H_ACT(1280), .V_ACT(720),
      .TIMEOUT_FRAMES(3), .WB_PERIOD(3)
   ) dut (
      .clk(clk), .rst(rst), .vsync(vsync),
      .req_valid(req_valid), .req_ready(req_ready), .req_slot(req_slot),
      .req_sx(req_sx), .req_ex(req_ex), .req_sy(req_sy), .req_ey(req_ey),
      .req_color(req_color),
      .start_xs(start_xs), .end_xs(end_xs), .start_ys(start_ys), .end_ys(end_ys),
      .colors(colors), .box_valid(box_valid), .req_err(req_err),
      .wb_update(wb_update), .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard queues
   typedef struct {
      logic [N_REQ-1:0] gnt;
      logic             err;
   } gnt_t;
   gnt_t             gq[$];
   logic [SNW-1:0]   sq[$];
   int               wq[$];

   // Expected active bank, edited by hand as the sequence progresses
   logic             e_v  [N_BOX];
   logic [XW-1:0]    e_sx [N_BOX];
   logic [XW-1:0]    e_ex [N_BOX];
   logic [YW-1:0]    e_sy [N_BOX];
   logic [YW-1:0]    e_ey [N_BOX];
   logic [23:0]      e_col[N_BOX];

   task automatic set_box(input int s, input int sx, input int ex, input int sy, input int ey, input logic [23:0] col);
      e_v[s] = 1'b1; e_sx[s] = XW'(sx); e_ex[s] = XW'(ex);
      e_sy[s] = YW'(sy); e_ey[s] = YW'(ey); e_col[s] = col;
   endtask

   task automatic clr_box(input int s);
      e_v[s] = 1'b0; e_sx[s] = '1; e_ex[s] = '0; e_sy[s] = '1; e_ey[s] = '0; e_col[s] = '0;
   endtask

   task automatic push_snap();
      logic [N_BOX-1:0]    v;
      logic [N_BOX*XW-1:0] sx, ex;
      logic [N_BOX*YW-1:0] sy, ey;
      logic [N_BOX*24-1:0] col;
      for (int s = 0; s < N_BOX; s++) begin
         v[s] = e_v[s];
         sx[s*XW +: XW] = e_sx[s]; ex[s*XW +: XW] = e_ex[s];
         sy[s*YW +: YW] = e_sy[s]; ey[s*YW +: YW] = e_ey[s];
         col[s*24 +: 24] = e_col[s];
      end
      sq.push_back({v, sx, ex, sy, ey, col});
   endtask

   // Monitor: compare every grant, error pulse, bank change and wb strobe
   logic [SNW-1:0] prev_snap = 'x;
   logic [SNW-1:0] cur_snap;
   logic           err_pending = 1'b0;
   logic           err_exp     = 1'b0;
   gnt_t           g_e;

   always @(negedge clk) begin
      if (err_pending)
         check("req_err", req_err, err_exp);
      else if (req_err)
         check("unexpected_req_err", req_err, 0);
      err_pending = 1'b0;

      if (req_ready != '0) begin
         if (gq.size() == 0) begin
            check("unexpected_grant", req_ready, 0);
         end else begin
            g_e = gq.pop_front();
            check("grant", req_ready, g_e.gnt);
            err_pending = 1'b1;
            err_exp     = g_e.err;
         end
      end

      cur_snap = {box_valid, start_xs, end_xs, start_ys, end_ys, colors};
      if (cur_snap !== prev_snap) begin
         if (sq.size() == 0)
            check("unexpected_box_change", cur_snap, prev_snap);
         else
            check("box_bank", cur_snap, sq.pop_front());
      end
      prev_snap = cur_snap;

      if (wb_update) begin
         if (wq.size() == 0)
            check("unexpected_wb_update", wb_update, 0);
         else
            check("wb_update_frame", frame_cnt, wq.pop_front());
      end
   end

   // Stimulus helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic vsync_pulse();
      vsync = 1'b1; tick(); tick();
      vsync = 1'b0; tick(); tick();
   endtask

   task automatic set_fields(input int i, input int slot, input int sx, input int ex,
                             input int sy, input int ey, input logic [23:0] col);
      req_slot[i*SW +: SW]  = SW'(slot);
      req_sx[i*XW +: XW]    = XW'(sx);
      req_ex[i*XW +: XW]    = XW'(ex);
      req_sy[i*YW +: YW]    = YW'(sy);
      req_ey[i*YW +: YW]    = YW'(ey);
      req_color[i*24 +: 24] = col;
   endtask

   task automatic do_req(input int i, input int slot, input int sx, input int ex,
                         input int sy, input int ey, input logic [23:0] col,
                         input logic [N_REQ-1:0] gnt, input logic err);
      set_fields(i, slot, sx, ex, sy, ey, col);
      gq.push_back('{gnt: gnt, err: err});
      req_valid[i] = 1'b1;
      tick();
      req_valid[i] = 1'b0;
   endtask

   initial begin
      rst = 1'b1; vsync = 1'b1; req_valid = '0;
      req_slot = '0; req_sx = '0; req_ex = '0; req_sy = '0; req_ey = '0; req_color = '0;
      for (int s = 0; s < N_BOX; s++) clr_box(s);
      push_snap();
      wq.push_back(3); wq.push_back(6); wq.push_back(9);

      // Reset released with vsync already high: no frame start
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();
      check("frame_cnt_after_reset", frame_cnt, 0);
      check("box_valid_after_reset", box_valid, 0);
      vsync = 1'b0;
      repeat (3) tick();

      // Basic write: lands in shadow, visible only after the next frame start
      vsync_pulse();                                                   // edge 1
      do_req(0, 1, 100, 200, 50, 120, 24'hFF0000, 2'b01, 1'b0);
      repeat (3) tick();
      set_box(1, 100, 200, 50, 120, 24'hFF0000);
      push_snap();
      vsync_pulse();                                                   // edge 2
      check("box_valid_basic", box_valid, 4'b0010);

      // Round-robin: pointer sits at 1 after the grant to req0
      set_fields(0, 3, 500, 600, 300, 400, 24'h0000FF);
      set_fields(1, 2, 10, 20, 30, 40, 24'h00FF00);
      gq.push_back('{gnt: 2'b10, err: 1'b0}); gq.push_back('{gnt: 2'b01, err: 1'b0});
      gq.push_back('{gnt: 2'b10, err: 1'b0}); gq.push_back('{gnt: 2'b01, err: 1'b0});
      req_valid = 2'b11;
      repeat (4) tick();
      gq.push_back('{gnt: 2'b10, err: 1'b0}); gq.push_back('{gnt: 2'b10, err: 1'b0});
      gq.push_back('{gnt: 2'b10, err: 1'b0});
      req_valid = 2'b10;
      repeat (3) tick();
      req_valid = '0;
      tick();
      set_box(2, 10, 20, 30, 40, 24'h00FF00);
      set_box(3, 500, 600, 300, 400, 24'h0000FF);
      push_snap();
      vsync_pulse();                                                   // edge 3, wb

      // Edge collision: slot0 (age saturated at 3) is cleared this edge, the write survives in shadow
      vsync = 1'b1;
      set_fields(0, 0, 0, 0, 0, 0, 24'h123456);
      gq.push_back('{gnt: 2'b01, err: 1'b0});
      req_valid = 2'b01;
      tick();                                                          // edge 4
      req_valid = '0;
      tick();
      vsync = 1'b0;
      tick(); tick();
      // Edge 5: collision write appears; slot1 unrefreshed for 3 edges expires
      set_box(0, 0, 0, 0, 0, 24'h123456);
      clr_box(1);
      push_snap();
      vsync_pulse();                                                   // edge 5
      check("box_valid_after_collision", box_valid, 4'b1101);

      // Refresh slot2 every frame; slot3 and slot0 age out
      do_req(1, 2, 10, 20, 30, 40, 24'h00FF00, 2'b10, 1'b0);
      clr_box(3);
      push_snap();
      vsync_pulse();                                                   // edge 6, wb
      do_req(1, 2, 10, 20, 30, 40, 24'h00FF00, 2'b10, 1'b0);
      vsync_pulse();                                                   // edge 7
      do_req(1, 2, 10, 20, 30, 40, 24'h00FF00, 2'b10, 1'b0);
      clr_box(0);
      push_snap();
      vsync_pulse();                                                   // edge 8
      do_req(1, 2, 10, 20, 30, 40, 24'h00FF00, 2'b10, 1'b0);
      vsync_pulse();                                                   // edge 9, wb
      check("box_valid_refreshed", box_valid, 4'b0100);

      // Illegal requests are acked and flagged; legal extreme bounds accepted
      do_req(0, 1, 300, 200, 0, 10, 24'h111111, 2'b01, 1'b1);
      do_req(0, 3, 0, 1280, 0, 10, 24'h222222, 2'b01, 1'b1);
      do_req(0, 1, 0, 10, 100, 50, 24'h333333, 2'b01, 1'b1);
      do_req(0, 1, 0, 10, 0, 720, 24'h444444, 2'b01, 1'b1);
      do_req(0, 3, 0, 1279, 0, 719, 24'hABCDEF, 2'b01, 1'b0);
      tick();
      set_box(3, 0, 1279, 0, 719, 24'hABCDEF);
      push_snap();
      vsync_pulse();                                                   // edge 10
      check("frame_cnt_10", frame_cnt, 10);

      // Reset mid-frame with a pending request: no grant, everything cleared
      rst = 1'b1;
      vsync = 1'b1;
      set_fields(0, 0, 1, 2, 3, 4, 24'h555555);
      req_valid = 2'b01;
      #1;
      check("req_ready_in_reset", req_ready, 0);
      for (int s = 0; s < N_BOX; s++) clr_box(s);
      push_snap();
      tick();
      check("frame_cnt_mid_reset", frame_cnt, 0);
      check("box_valid_mid_reset", box_valid, 0);
      check("wb_update_mid_reset", wb_update, 0);
      req_valid = '0;
      rst = 1'b0;
      wq.push_back(3); wq.push_back(6);
      tick(); tick();
      vsync = 1'b0;
      tick(); tick();
      for (int n = 0; n < 7; n++) vsync_pulse();
      check("frame_cnt_7", frame_cnt, 7);
      repeat (3) tick();

      check("grant_queue_drained", gq.size(), 0);
      check("bank_queue_drained", sq.size(), 0);
      check("wb_queue_drained", wq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
